// File: rtl/exbus_pkg.sv
// Shared definitions for the exbus packet FIFO family.
// Holds the write-side state encoding used by expktfifo and a pointer
// increment helper shared by the address registers.
package exbus_pkg;

  // Write-side packet state.
  // IDLE: no packet is open.
  // OPEN: words of an uncommitted packet are held.
  // DROP: an overflowed packet is being discarded until its last word.
  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_OPEN = 2'd1,
    WR_DROP = 2'd2
  } wr_state_t;

  // Pointer increment helper. Pointers are one bit wider than the
  // RAM address, so the sum wraps naturally modulo twice the depth.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr);
    ptr_inc = ptr + 32'd1;
  endfunction

endpackage

// File: rtl/exfifo_mem.sv
// Simple dual-port storage for expktfifo.
// Synchronous write port, asynchronous (combinational) read port.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, combinational from raddr
module exfifo_mem #(
  parameter int W  = 9,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:(1<<AW)-1];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/expktfifo.sv
// Packet FIFO: words become visible to the reader only once the final word
// of their packet has been written. Open packets can be aborted, and a
// packet that overflows the buffer is either discarded whole
// (OPT_DROP_ON_OVERFLOW=1) or loses only the overflowing word.
// Ports:
//   i_clk, i_reset          - clock, synchronous active-high reset
//   i_wr, i_data, i_last    - write strobe, data, end-of-packet marker
//   i_abort                 - discard the open packet
//   o_full, o_afull, o_fill - occupancy (committed plus uncommitted words)
//   o_pkts                  - committed packets not yet fully read
//   o_overflow              - one-cycle pulse on a rejected overflow write
//   o_valid, i_ready        - read handshake
//   o_data, o_last          - head-of-queue word
module expktfifo
  import exbus_pkg::*;
#(
  parameter int BW                   = 8,
  parameter int LGFLEN               = 4,
  parameter int AFULL                = (1 << LGFLEN) - 2,
  parameter bit OPT_DROP_ON_OVERFLOW = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wr,
  input  logic [BW-1:0]   i_data,
  input  logic            i_last,
  input  logic            i_abort,
  output logic            o_full,
  output logic            o_afull,
  output logic [LGFLEN:0] o_fill,
  output logic [LGFLEN:0] o_pkts,
  output logic            o_overflow,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [BW-1:0]   o_data,
  output logic            o_last
);

  localparam logic [LGFLEN:0] FLEN_W  = {1'b1, {LGFLEN{1'b0}}};
  localparam logic [LGFLEN:0] AFULL_W = AFULL[LGFLEN:0];

  wr_state_t       state, state_nxt;
  logic [LGFLEN:0] wr_addr, wr_addr_nxt;
  logic [LGFLEN:0] cm_addr, cm_addr_nxt;
  logic [LGFLEN:0] rd_addr;
  logic [LGFLEN:0] wr_addr_inc;
  logic [LGFLEN:0] pkts, pkts_nxt;
  logic            overflow;
  logic            wr_ok;
  logic            ovf_evt;
  logic            rd_en;
  logic [BW:0]     rd_word;
  logic [31:0]     wr_inc_full;

  assign o_fill  = wr_addr - rd_addr;
  assign o_full  = (o_fill == FLEN_W);
  assign o_afull = (o_fill >= AFULL_W);
  assign o_valid = (rd_addr != cm_addr);
  assign o_pkts  = pkts;
  assign o_overflow = overflow;
  assign o_last  = rd_word[BW];
  assign o_data  = rd_word[BW-1:0];

  // Fullness is judged on the registered fill, so a read in the same
  // cycle never makes room for a write.
  assign rd_en   = o_valid && i_ready;
  assign wr_ok   = i_wr && !o_full && (state != WR_DROP) && !i_abort;
  assign ovf_evt = i_wr && o_full && (state != WR_DROP) && !i_abort;

  assign wr_inc_full = ptr_inc({{(31-LGFLEN){1'b0}}, wr_addr});
  assign wr_addr_inc = wr_inc_full[LGFLEN:0];

  // Write-side next state and write/commit pointer updates.
  always_comb begin
    state_nxt   = state;
    wr_addr_nxt = wr_addr;
    cm_addr_nxt = cm_addr;
    if (i_abort) begin
      state_nxt   = WR_IDLE;
      wr_addr_nxt = cm_addr;
    end else if (ovf_evt) begin
      if (OPT_DROP_ON_OVERFLOW) begin
        wr_addr_nxt = cm_addr;
        state_nxt   = i_last ? WR_IDLE : WR_DROP;
      end else begin
        state_nxt = state;
      end
    end else begin
      case (state)
        WR_IDLE, WR_OPEN: begin
          if (wr_ok) begin
            wr_addr_nxt = wr_addr_inc;
            if (i_last) begin
              cm_addr_nxt = wr_addr_inc;
              state_nxt   = WR_IDLE;
            end else begin
              state_nxt = WR_OPEN;
            end
          end else begin
            state_nxt = state;
          end
        end
        WR_DROP: begin
          if (i_wr && i_last) begin
            state_nxt = WR_IDLE;
          end else begin
            state_nxt = WR_DROP;
          end
        end
        default: state_nxt = WR_IDLE;
      endcase
    end
  end

  // Packet count: a commit and a last-word read on the same edge cancel.
  always_comb begin
    pkts_nxt = pkts;
    case ({wr_ok && i_last, rd_en && o_last})
      2'b10:   pkts_nxt = pkts + 1'b1;
      2'b01:   pkts_nxt = pkts - 1'b1;
      default: pkts_nxt = pkts;
    endcase
  end

  // Pointer, count, state and overflow-pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= WR_IDLE;
      wr_addr  <= '0;
      cm_addr  <= '0;
      rd_addr  <= '0;
      pkts     <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      wr_addr  <= wr_addr_nxt;
      cm_addr  <= cm_addr_nxt;
      rd_addr  <= rd_en ? rd_addr + 1'b1 : rd_addr;
      pkts     <= pkts_nxt;
      overflow <= ovf_evt;
    end
  end

  exfifo_mem #(
    .W  (BW + 1),
    .AW (LGFLEN)
  ) u_mem (
    .clk   (i_clk),
    .we    (wr_ok && !i_reset),
    .waddr (wr_addr[LGFLEN-1:0]),
    .wdata ({i_last, i_data}),
    .raddr (rd_addr[LGFLEN-1:0]),
    .rdata (rd_word)
  );

endmodule

// File: tb/tb_expktfifo.sv
// Scoreboard bench for expktfifo (BW=8, LGFLEN=4, drop-on-overflow).
// Stimulus pushes expected {last,data} words for packets that should be
// delivered; a negedge monitor pops and compares on every handshake.
module tb_expktfifo;

  logic       clk;
  logic       i_reset;
  logic       i_wr;
  logic [7:0] i_data;
  logic       i_last;
  logic       i_abort;
  logic       o_full;
  logic       o_afull;
  logic [4:0] o_fill;
  logic [4:0] o_pkts;
  logic       o_overflow;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_last;

  int n_chk  = 0;
  int n_pass = 0;
  logic [8:0] sb_q[$];
  logic [8:0] exp_word;

  expktfifo #(
    .BW(8), .LGFLEN(4), .AFULL(14), .OPT_DROP_ON_OVERFLOW(1'b1)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_wr(i_wr), .i_data(i_data),
    .i_last(i_last), .i_abort(i_abort), .o_full(o_full), .o_afull(o_afull),
    .o_fill(o_fill), .o_pkts(o_pkts), .o_overflow(o_overflow),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic last);
    i_wr   = 1'b1;
    i_data = d;
    i_last = last;
    step();
    i_wr   = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic expect_word(input logic [7:0] d, input logic last);
    sb_q.push_back({last, d});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    i_ready = 1'b1;
    while (sb_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    step();
    check({name, "_sb_empty"}, sb_q.size(), 32'd0);
    check({name, "_valid_after"}, o_valid, 32'd0);
    check({name, "_pkts_after"}, o_pkts, 32'd0);
  endtask

  // Monitor: every handshake on the read port is compared with the scoreboard.
  always @(negedge clk) begin
    if (!i_reset && o_valid && i_ready) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: got %0h expected none", {o_last, o_data});
      end else begin
        exp_word = sb_q.pop_front();
        check("sb_word", {o_last, o_data}, exp_word);
      end
    end
  end

  initial begin
    i_reset = 1'b1;
    i_wr = 1'b0; i_data = 8'h00; i_last = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
    step(); step();
    i_reset = 1'b0;
    check("rst_fill", o_fill, 32'd0);
    check("rst_valid", o_valid, 32'd0);
    check("rst_pkts", o_pkts, 32'd0);
    check("rst_full", o_full, 32'd0);

    // Three-word packet: invisible until the last word commits.
    expect_word(8'hA1, 1'b0); expect_word(8'hB2, 1'b0); expect_word(8'hC3, 1'b1);
    wr(8'hA1, 1'b0); check("abc_valid_a", o_valid, 32'd0);
    wr(8'hB2, 1'b0); check("abc_valid_b", o_valid, 32'd0);
    check("abc_pkts_b", o_pkts, 32'd0);
    wr(8'hC3, 1'b1); check("abc_valid_c", o_valid, 32'd1);
    check("abc_pkts_c", o_pkts, 32'd1);
    check("abc_fill", o_fill, 32'd3);
    drain("abc");

    // Abort of an open packet, reader ready the whole time.
    i_ready = 1'b1;
    wr(8'h51, 1'b0); check("abort_valid1", o_valid, 32'd0);
    wr(8'h52, 1'b0); check("abort_valid2", o_valid, 32'd0);
    check("abort_fill_pre", o_fill, 32'd2);
    i_abort = 1'b1; step(); i_abort = 1'b0;
    check("abort_fill", o_fill, 32'd0);
    check("abort_valid", o_valid, 32'd0);
    check("abort_pkts", o_pkts, 32'd0);
    i_ready = 1'b0;

    // 17-word packet overflows and is dropped until its last word.
    for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
    check("ovf_full", o_full, 32'd1);
    check("ovf_fill16", o_fill, 32'd16);
    check("ovf_pulse_pre", o_overflow, 32'd0);
    wr(8'h77, 1'b0);
    check("ovf_pulse", o_overflow, 32'd1);
    check("ovf_fill0", o_fill, 32'd0);
    wr(8'h78, 1'b0);
    check("ovf_pulse_end", o_overflow, 32'd0);
    check("ovf_drop_fill", o_fill, 32'd0);
    wr(8'h79, 1'b1);
    check("ovf_drop_last_fill", o_fill, 32'd0);
    check("ovf_drop_pkts", o_pkts, 32'd0);
    expect_word(8'h5A, 1'b0); expect_word(8'h5B, 1'b1);
    wr(8'h5A, 1'b0); wr(8'h5B, 1'b1);
    check("ovf_next_pkts", o_pkts, 32'd1);
    drain("ovf");

    // Commit a one-word packet while the previous last word is read.
    i_ready = 1'b0;
    expect_word(8'h40, 1'b1);
    wr(8'h40, 1'b1);
    check("simul_pkts_pre", o_pkts, 32'd1);
    expect_word(8'h41, 1'b1);
    i_ready = 1'b1;
    wr(8'h41, 1'b1);
    check("simul_pkts", o_pkts, 32'd1);
    drain("simul");

    // Almost-full and full thresholds with one-word packets.
    i_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      expect_word(8'h80 + 8'(i), 1'b1);
      wr(8'h80 + 8'(i), 1'b1);
    end
    check("afull_13", o_afull, 32'd0);
    expect_word(8'h8D, 1'b1); wr(8'h8D, 1'b1);
    check("afull_14", o_afull, 32'd1);
    check("full_14", o_full, 32'd0);
    expect_word(8'h8E, 1'b1); wr(8'h8E, 1'b1);
    expect_word(8'h8F, 1'b1); wr(8'h8F, 1'b1);
    check("full_16", o_full, 32'd1);
    check("pkts_16", o_pkts, 32'd16);
    i_ready = 1'b1;
    wr(8'hEE, 1'b1);
    check("full_reject_ovf", o_overflow, 32'd1);
    check("full_reject_fill", o_fill, 32'd15);
    check("full_reject_pkts", o_pkts, 32'd15);
    drain("full");

    // Reset with five committed and two open words.
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i), (i == 4) ? 1'b1 : 1'b0);
    wr(8'h20, 1'b0); wr(8'h21, 1'b0);
    check("prerst_fill", o_fill, 32'd7);
    check("prerst_pkts", o_pkts, 32'd1);
    i_reset = 1'b1; i_wr = 1'b1; i_data = 8'h99; i_last = 1'b1;
    step();
    i_reset = 1'b0; i_wr = 1'b0; i_last = 1'b0;
    check("mrst_fill", o_fill, 32'd0);
    check("mrst_pkts", o_pkts, 32'd0);
    check("mrst_valid", o_valid, 32'd0);
    check("mrst_full", o_full, 32'd0);
    check("mrst_afull", o_afull, 32'd0);
    check("mrst_ovf", o_overflow, 32'd0);
    expect_word(8'h31, 1'b0); expect_word(8'h32, 1'b1);
    wr(8'h31, 1'b0); wr(8'h32, 1'b1);
    check("mrst_next_pkts", o_pkts, 32'd1);
    drain("mrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/expktfifo.md
EXPKTFIFO -- requirements
Module: expktfifo

Interface
REQ-001 SHALL have parameter BW, default 8, data width in bits.
REQ-002 SHALL have parameter LGFLEN, default 4, log2 of depth; depth FLEN = 2^LGFLEN words.
REQ-003 SHALL have parameter AFULL, default FLEN-2, fill level at or above which o_afull asserts.
REQ-004 SHALL have parameter OPT_DROP_ON_OVERFLOW, default 1; 1 = an overflowing packet is discarded, 0 = the overflowing word alone is lost.
REQ-005 i_clk  in  1  clock; all state changes on its rising edge.
REQ-006 i_reset  in  1  synchronous, active-high reset.
REQ-007 i_wr  in  1  write strobe.
REQ-008 i_data  in  BW  write data.
REQ-009 i_last  in  1  the word written is the final word of its packet.
REQ-010 i_abort  in  1  discard the open (uncommitted) packet.
REQ-011 o_full  out  1  no free word (committed plus uncommitted = FLEN).
REQ-012 o_afull  out  1  o_fill >= AFULL.
REQ-013 o_fill  out  LGFLEN+1  words held, committed plus uncommitted.
REQ-014 o_pkts  out  LGFLEN+1  count of committed packets not yet fully read.
REQ-015 o_overflow  out  1  one-cycle pulse when a packet is dropped for overflow.
REQ-016 o_valid  out  1  committed word available at output.
REQ-017 i_ready  in  1  consumer accepts the word when o_valid and i_ready are both high.
REQ-018 o_data  out  BW  head-of-queue data; o_last  out  1  head word ends its packet.

Function
REQ-019 SHALL hold three LGFLEN+1-bit pointers: wr_addr (next write), cm_addr (end of committed data), rd_addr (head); words are stored BW+1 wide, {last, data}.
REQ-020 An accepted write (i_wr && !o_full && write state != DROP && !i_abort) SHALL store {i_last, i_data} at wr_addr and increment wr_addr, wrapping modulo 2^(LGFLEN+1).
REQ-021 An accepted write with i_last SHALL set cm_addr to the new wr_addr and increment o_pkts on the same edge.
REQ-022 Write state machine: IDLE (no open packet) -> OPEN on an accepted write without i_last; OPEN -> IDLE on an accepted write with i_last; any state -> IDLE on i_abort.
REQ-023 i_abort SHALL set wr_addr to cm_addr; a write presented in the same cycle SHALL be discarded.
REQ-024 i_wr while o_full with OPT_DROP_ON_OVERFLOW=1: wr_addr <= cm_addr, o_overflow pulses one cycle, state -> DROP (IDLE if i_last is high).
REQ-025 In DROP, writes SHALL be discarded; a write with i_last returns the state to IDLE without committing.
REQ-026 With OPT_DROP_ON_OVERFLOW=0, a write while full SHALL be discarded, o_overflow SHALL pulse, and the state SHALL be unchanged.
REQ-027 o_valid SHALL equal (rd_addr != cm_addr); o_data/o_last SHALL be read combinationally from mem[rd_addr]; uncommitted words are never visible.
REQ-028 Latency: a word committed at edge N SHALL present o_valid=1 in the cycle after edge N.
REQ-029 A read (o_valid && i_ready) SHALL increment rd_addr; a read with o_last SHALL decrement o_pkts; simultaneous commit and last-word read SHALL leave o_pkts unchanged.
REQ-030 o_fill SHALL equal wr_addr - rd_addr at all times; o_full = (o_fill == FLEN); a simultaneous read SHALL NOT free space for a write in the same cycle.
REQ-031 A write with i_last while in IDLE SHALL be a valid one-word packet.

Reset
REQ-032 On i_reset, SHALL set all pointers to 0, state to IDLE, and o_pkts, o_fill, o_overflow, o_valid, o_full and o_afull to 0; inputs in the reset cycle SHALL be ignored.
REQ-033 Reset mid-packet SHALL discard all stored and open data.

Structure
REQ-034 Write-state encoding (IDLE, OPEN, DROP) SHALL reside in shared package exbus_pkg.
REQ-035 Storage SHALL be one sub-module, exfifo_mem: a simple dual-port RAM, (BW+1)-wide, FLEN deep, synchronous write and asynchronous read.

Verification
REQ-036 Write 3 words A,B,C (C with i_last) -> o_valid stays 0 until the cycle after C; then reads A,B,C with o_last only on C; o_pkts goes 0->1->0.
REQ-037 Write 2 words, then assert i_abort -> o_fill returns to 0, o_valid is never 1, o_pkts stays 0.
REQ-038 LGFLEN=4: write a 17-word packet -> o_overflow pulses on word 17, o_fill=0 afterward, later words are ignored until i_last; the next 2-word packet is read intact.
REQ-039 Commit a 1-word packet while reading the last word of the previous packet in the same cycle -> o_pkts unchanged, order preserved.
REQ-040 Fill to 14 words -> o_afull=1 at fill 14, 0 at 13; fill 16 -> o_full=1; a write while full with i_ready=1 is rejected.
REQ-041 Assert i_reset with 5 committed and 2 open words -> all outputs 0 the next cycle; a subsequent packet is read correctly.
